pulse_generator_core: RTL and testbench

- Consumes the pulse-generator configuration register outputs: enable, start date/time, and 24-bit high-width/period bytes.
- Arms on enable, waits for the second boundary whose wall-clock time equals the programmed start time, then emits a periodic pulse timed in microseconds.
- Sits between the pulse-generator register bank and the board pulse output pin.
- Time base comes from the clock/RTC section as a 1 µs tick, a PPS strobe and the current time bytes.

---
 rtl/pulse_generator_core_if.sv | 63 ++++++
 rtl/pulse_generator_core.sv | 156 +++++++++++++++
 tb/tb_pulse_generator_core.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/pulse_generator_core_if.sv
// Bundle of the pulse generator's time base, configuration and status signals.
// master: register bank / RTC side (drives time and config, reads status).
// slave : pulse_generator_core.
interface pulse_generator_core_if #(
  parameter int DATA_WIDTH = 8
);
  // time base from the clock/RTC section
  logic                  i_us_tick;
  logic                  i_pps;
  logic [DATA_WIDTH-1:0] i_cur_year_h;
  logic [DATA_WIDTH-1:0] i_cur_year_l;
  logic [DATA_WIDTH-1:0] i_cur_month;
  logic [DATA_WIDTH-1:0] i_cur_day;
  logic [DATA_WIDTH-1:0] i_cur_hour;
  logic [DATA_WIDTH-1:0] i_cur_minutes;
  logic [DATA_WIDTH-1:0] i_cur_seconds;

  // configuration register outputs
  logic [DATA_WIDTH-1:0] i_pulse_enable;
  logic [DATA_WIDTH-1:0] i_usr_year_h;
  logic [DATA_WIDTH-1:0] i_usr_year_l;
  logic [DATA_WIDTH-1:0] i_usr_month;
  logic [DATA_WIDTH-1:0] i_usr_day;
  logic [DATA_WIDTH-1:0] i_usr_hour;
  logic [DATA_WIDTH-1:0] i_usr_minutes;
  logic [DATA_WIDTH-1:0] i_usr_seconds;
  logic [DATA_WIDTH-1:0] i_width_high_2;
  logic [DATA_WIDTH-1:0] i_width_high_1;
  logic [DATA_WIDTH-1:0] i_width_high_0;
  logic [DATA_WIDTH-1:0] i_width_period_2;
  logic [DATA_WIDTH-1:0] i_width_period_1;
  logic [DATA_WIDTH-1:0] i_width_period_0;

  // status / pin
  logic                  o_pulse;
  logic                  o_armed;
  logic                  o_running;
  logic [15:0]           o_period_count;

  modport master (
    output i_us_tick, i_pps,
    output i_cur_year_h, i_cur_year_l, i_cur_month, i_cur_day,
    output i_cur_hour, i_cur_minutes, i_cur_seconds,
    output i_pulse_enable,
    output i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day,
    output i_usr_hour, i_usr_minutes, i_usr_seconds,
    output i_width_high_2, i_width_high_1, i_width_high_0,
    output i_width_period_2, i_width_period_1, i_width_period_0,
    input  o_pulse, o_armed, o_running, o_period_count
  );

  modport slave (
    input  i_us_tick, i_pps,
    input  i_cur_year_h, i_cur_year_l, i_cur_month, i_cur_day,
    input  i_cur_hour, i_cur_minutes, i_cur_seconds,
    input  i_pulse_enable,
    input  i_usr_year_h, i_usr_year_l, i_usr_month, i_usr_day,
    input  i_usr_hour, i_usr_minutes, i_usr_seconds,
    input  i_width_high_2, i_width_high_1, i_width_high_0,
    input  i_width_period_2, i_width_period_1, i_width_period_0,
    output o_pulse, o_armed, o_running, o_period_count
  );
endinterface

// File: rtl/pulse_generator_core.sv
// Pulse generator core: arms on enable, starts on the PPS whose wall-clock
// time equals the programmed start time, then emits a microsecond-timed
// periodic (or one-shot when period is 0) pulse.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | disabled; counter, pulse and period count held at zero
// ST_ARMED   | enabled, waiting for a PPS at the programmed start time
// ST_RUNNING | generating pulses from the shadowed width/period
module pulse_generator_core #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 3 * DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  pulse_generator_core_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_RUNNING = 2'd2
  } state_t;

  state_t               state_q, state_nxt;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_nxt;
  logic [CNT_WIDTH-1:0] width_q, width_nxt;
  logic [CNT_WIDTH-1:0] period_q, period_nxt;
  logic                 pulse_q, pulse_nxt;
  logic [15:0]          pcount_q, pcount_nxt;
  logic                 armed_q, running_q;

  logic                 enable;
  logic                 time_match;
  logic                 start;
  logic [CNT_WIDTH-1:0] width_in;
  logic [CNT_WIDTH-1:0] period_in;
  logic                 unused_enable_bits;

  assign enable = bus.i_pulse_enable[0];
  assign unused_enable_bits = ^bus.i_pulse_enable[DATA_WIDTH-1:1];

  assign time_match = (bus.i_cur_year_h  == bus.i_usr_year_h)  &&
                      (bus.i_cur_year_l  == bus.i_usr_year_l)  &&
                      (bus.i_cur_month   == bus.i_usr_month)   &&
                      (bus.i_cur_day     == bus.i_usr_day)     &&
                      (bus.i_cur_hour    == bus.i_usr_hour)    &&
                      (bus.i_cur_minutes == bus.i_usr_minutes) &&
                      (bus.i_cur_seconds == bus.i_usr_seconds);

  assign start = bus.i_pps && time_match;

  assign width_in  = {bus.i_width_high_2, bus.i_width_high_1, bus.i_width_high_0};
  assign period_in = {bus.i_width_period_2, bus.i_width_period_1, bus.i_width_period_0};

  // State register; status flags are registered decodes of the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      armed_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      armed_q   <= (state_nxt == ST_ARMED);
      running_q <= (state_nxt == ST_RUNNING);
    end
  end

  // Next-state logic: disable always wins, start needs PPS plus full time match.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (enable) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!enable)    state_nxt = ST_IDLE;
        else if (start) state_nxt = ST_RUNNING;
      end
      ST_RUNNING: if (!enable) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values: counter, shadows, pulse and period count.
  always_comb begin
    cnt_nxt    = cnt_q;
    width_nxt  = width_q;
    period_nxt = period_q;
    pulse_nxt  = pulse_q;
    pcount_nxt = pcount_q;
    case (state_q)
      ST_ARMED: begin
        cnt_nxt    = '0;
        pulse_nxt  = 1'b0;
        pcount_nxt = '0;
        // a us tick coinciding with the start PPS is deliberately ignored
        if (enable && start) begin
          width_nxt  = width_in;
          period_nxt = period_in;
          pulse_nxt  = (width_in != '0);
        end
      end
      ST_RUNNING: begin
        if (!enable) begin
          cnt_nxt    = '0;
          pulse_nxt  = 1'b0;
          pcount_nxt = '0;
        end else if (bus.i_us_tick) begin
          if (period_q != '0) begin
            if (cnt_q == period_q - CNT_WIDTH'(1)) begin
              // register writes made during a period only land here
              cnt_nxt    = '0;
              pcount_nxt = pcount_q + 16'd1;
              width_nxt  = width_in;
              period_nxt = period_in;
            end else begin
              cnt_nxt = cnt_q + CNT_WIDTH'(1);
            end
          end else begin
            // one-shot: count up to the width and park there
            if (cnt_q < width_q) cnt_nxt = cnt_q + CNT_WIDTH'(1);
            if (cnt_nxt == width_q) pcount_nxt = 16'd1;
          end
          pulse_nxt = (cnt_nxt < width_nxt);
        end
      end
      default: begin
        cnt_nxt    = '0;
        pulse_nxt  = 1'b0;
        pcount_nxt = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q    <= '0;
      width_q  <= '0;
      period_q <= '0;
      pulse_q  <= 1'b0;
      pcount_q <= '0;
    end else begin
      cnt_q    <= cnt_nxt;
      width_q  <= width_nxt;
      period_q <= period_nxt;
      pulse_q  <= pulse_nxt;
      pcount_q <= pcount_nxt;
    end
  end

  assign bus.o_pulse        = pulse_q;
  assign bus.o_armed        = armed_q;
  assign bus.o_running      = running_q;
  assign bus.o_period_count = pcount_q;

endmodule

// File: tb/tb_pulse_generator_core.sv
// Directed bench for pulse_generator_core: a vector table for arm/start and
// the first periods, plus hand-written sequences for the multi-cycle cases.
module tb_pulse_generator_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;
  logic [23:0] cfg_width  = 24'd3;
  logic [23:0] cfg_period = 24'd10;

  pulse_generator_core_if #(.DATA_WIDTH(8)) bus ();

  pulse_generator_core #(.DATA_WIDTH(8), .CNT_WIDTH(24)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    bit    en;
    bit    tick;
    bit    pps;
    int    mis;       // 0 = current time matches start, 1..7 = field that differs
    bit    exp_pulse;
    bit    exp_armed;
    bit    exp_running;
    int    exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string nm, bit en, bit tick, bit pps, int mis,
                              bit p, bit a, bit r, int c);
    vec_t v;
    v.name = nm; v.en = en; v.tick = tick; v.pps = pps; v.mis = mis;
    v.exp_pulse = p; v.exp_armed = a; v.exp_running = r; v.exp_count = c;
    return v;
  endfunction

  task automatic check(string nm, int act, int exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic expect_out(string nm, bit p, bit a, bit r, int c);
    check({nm, ".pulse"},   int'(bus.o_pulse),        int'(p));
    check({nm, ".armed"},   int'(bus.o_armed),        int'(a));
    check({nm, ".running"}, int'(bus.o_running),      int'(r));
    check({nm, ".count"},   int'(bus.o_period_count), c);
  endtask

  task automatic set_time(int mis);
    bus.i_cur_year_h  = (mis == 1) ? 8'h21 : 8'h20;
    bus.i_cur_year_l  = (mis == 2) ? 8'h25 : 8'h24;
    bus.i_cur_month   = (mis == 3) ? 8'd4  : 8'd3;
    bus.i_cur_day     = (mis == 4) ? 8'd16 : 8'd15;
    bus.i_cur_hour    = (mis == 5) ? 8'd11 : 8'd10;
    bus.i_cur_minutes = (mis == 6) ? 8'd21 : 8'd20;
    bus.i_cur_seconds = (mis == 7) ? 8'd31 : 8'd30;
  endtask

  // one clock: drive inputs, take the edge, sample 1 time unit later
  task automatic step(bit en, bit tick, bit pps, int mis);
    bus.i_pulse_enable   = {7'b1010010, en};
    bus.i_us_tick        = tick;
    bus.i_pps            = pps;
    set_time(mis);
    bus.i_width_high_2   = cfg_width[23:16];
    bus.i_width_high_1   = cfg_width[15:8];
    bus.i_width_high_0   = cfg_width[7:0];
    bus.i_width_period_2 = cfg_period[23:16];
    bus.i_width_period_1 = cfg_period[15:8];
    bus.i_width_period_0 = cfg_period[7:0];
    @(posedge clk);
    #1;
    bus.i_us_tick = 1'b0;
    bus.i_pps     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 7);
    step(1'b0, 1'b0, 1'b0, 7);
    rst = 1'b0;
  endtask

  task automatic start_run(logic [23:0] w, logic [23:0] p, string nm);
    do_reset();
    cfg_width  = w;
    cfg_period = p;
    step(1'b1, 1'b0, 1'b0, 7);
    step(1'b1, 1'b0, 1'b1, 0);
    expect_out({nm, ".start"}, (w != 0), 1'b0, 1'b1, 0);
  endtask

  initial begin
    bus.i_usr_year_h  = 8'h20;
    bus.i_usr_year_l  = 8'h24;
    bus.i_usr_month   = 8'd3;
    bus.i_usr_day     = 8'd15;
    bus.i_usr_hour    = 8'd10;
    bus.i_usr_minutes = 8'd20;
    bus.i_usr_seconds = 8'd30;
    bus.i_us_tick     = 1'b0;
    bus.i_pps         = 1'b0;
    bus.i_pulse_enable = 8'h00;
    set_time(7);

    // Test 1 table: width 3, period 10
    vecs.push_back(mk("reset_state",   0, 0, 0, 7, 0, 0, 0, 0));
    vecs.push_back(mk("idle_hold",     0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("arm",           1, 0, 0, 7, 0, 1, 0, 0));
    vecs.push_back(mk("pps_bad_yearh", 1, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk("pps_bad_sec",   1, 0, 1, 7, 0, 1, 0, 0));
    vecs.push_back(mk("match_no_pps",  1, 0, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk("start_tick",    1, 1, 1, 0, 1, 0, 1, 0));
    for (int k = 1; k <= 22; k++) begin
      vecs.push_back(mk($sformatf("t1_tick%0d", k), 1, 1, 0, 7,
                        ((k % 10) < 3), 0, 1, k / 10));
      if (k <= 4)
        vecs.push_back(mk($sformatf("t1_hold%0d", k), 1, 0, 0, 7,
                          ((k % 10) < 3), 0, 1, k / 10));
    end

    do_reset();
    cfg_width  = 24'd3;
    cfg_period = 24'd10;
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].tick, vecs[i].pps, vecs[i].mis);
      expect_out(vecs[i].name, vecs[i].exp_pulse, vecs[i].exp_armed,
                 vecs[i].exp_running, vecs[i].exp_count);
    end

    // Test 2: width rewritten mid-period lands at the next wrap
    start_run(24'd3, 24'd10, "t2");
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      if (k < 10) expect_out($sformatf("t2_tick%0d", k), (k < 3), 0, 1, 0);
      else        expect_out($sformatf("t2_tick%0d", k), ((k % 10) < 5), 0, 1, k / 10);
      if (k == 4) cfg_width = 24'd5;
    end

    // Test 3: one-shot, no retrigger on a later matching PPS
    start_run(24'd4, 24'd0, "t3");
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      expect_out($sformatf("t3_tick%0d", k), (k < 4), 0, 1, (k >= 4) ? 1 : 0);
    end
    step(1'b1, 1'b0, 1'b1, 0);
    expect_out("t3_pps_again", 0, 0, 1, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      expect_out($sformatf("t3_after%0d", k), 0, 0, 1, 1);
    end

    // Test 4: width >= period stays high; width 0 never high
    start_run(24'd12, 24'd10, "t4a");
    for (int k = 1; k <= 21; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      expect_out($sformatf("t4a_tick%0d", k), 1, 0, 1, k / 10);
    end
    start_run(24'd0, 24'd10, "t4b");
    for (int k = 1; k <= 21; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      expect_out($sformatf("t4b_tick%0d", k), 0, 0, 1, k / 10);
    end

    // Test 5: disable while high clears everything; re-enable arms in one cycle
    start_run(24'd3, 24'd10, "t5");
    for (int k = 1; k <= 12; k++) step(1'b1, 1'b1, 1'b0, 7);
    expect_out("t5_tick12", 1, 0, 1, 1);
    step(1'b0, 1'b0, 1'b0, 7);
    expect_out("t5_disable", 0, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 7);
    expect_out("t5_rearm", 0, 1, 0, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    expect_out("t5_restart", 1, 0, 1, 0);

    // Test 6: reset mid-run, then a start PPS with a coincident tick
    start_run(24'd3, 24'd10, "t6");
    step(1'b1, 1'b1, 1'b0, 7);
    expect_out("t6_high", 1, 0, 1, 0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b0, 7);
    expect_out("t6_reset", 0, 0, 0, 0);
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 7);
    expect_out("t6_idle_to_armed", 0, 1, 0, 0);
    cfg_width  = 24'd1;
    cfg_period = 24'd10;
    step(1'b1, 1'b1, 1'b1, 0);
    expect_out("t6_start_tick", 1, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b1, 1'b0, 7);
      expect_out($sformatf("t6_tick%0d", k), (k == 10), 0, 1, k / 10);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
